game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Parametrised game-flow controller for the Pac-Man FPGA design. It owns the game state machine, lives, level number, remaining-pill count, frightened (power-pill) timer, and N-ghost collision resolution. It drives the sprite/map/ghost reset and enable strobes consumed by the location controllers and map RAM writer. It generalises the current hard-coded 2-ghost, 3-life flow with level progression, power mode and pause.

Parameters:
N_GHOSTS, 2, number of ghost position channels (1..8)
X_W, 6, grid x coordinate width
Y_W, 5, grid y coordinate width
START_LIVES, 3, lives loaded on game start
MAX_LIVES, 7, lives saturation ceiling; LIVES_W = $clog2(MAX_LIVES+1)
PILLS_TOTAL, 300, pills per level; PILL_W = $clog2(PILLS_TOTAL+1)
RESUME_CYCLES, 250000000, post-death freeze length in CLOCK_50 cycles
CLEAR_CYCLES, 100000000, level-clear freeze length
FRIGHT_CYCLES, 300000000, frightened-mode duration
EXTRA_LIFE_PILLS, 1000, cumulative pills per bonus life (only with EXTRA_LIFE_EN)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
start  in  1  level-sensitive start request (SW)
pause  in  1  level-sensitive pause request
pac_x  in  X_W  pacman next grid x
pac_y  in  Y_W  pacman next grid y
ghost_x  in  N_GHOSTS*X_W  packed ghost next x; ghost i at [i*X_W +: X_W]
ghost_y  in  N_GHOSTS*Y_W  packed ghost next y
pill_eaten  in  1  one-cycle pulse per normal pill consumed
power_eaten  in  1  one-cycle pulse per power pill consumed
sprite_reset  out  1  holds sprite controllers at home positions
map_wr_reset  out  1  holds map RAM writer in reset
ghost_enable  out  1  ghost AI step enable
frightened  out  1  power mode active
ghost_eaten  out  N_GHOSTS  one-cycle pulse per ghost eaten
life_lost  out  1  one-cycle pulse on lethal collision
lives  out  LIVES_W  remaining lives
level  out  4  current level, saturates at 15
pills_left  out  PILL_W  pills remaining in level
state  out  3  encoded state for debug/HEX

Behaviour:
- States (encoding): IDLE=0, PLAY=1, RESUME=2, CLEAR=3, PAUSED=4, OVER=5. Reset -> IDLE, lives=START_LIVES, level=0, pills_left=PILLS_TOTAL, frightened=0, all pulses 0, timers 0.
- Outputs by state: IDLE sprite_reset=1 map_wr_reset=1 ghost_enable=0; PLAY 0/0/1; RESUME 1/0/0; CLEAR 1/1/0; PAUSED 0/0/0; OVER 0/1/0. Registered (change the cycle after the state change).
- IDLE: start=1 -> PLAY; load lives=START_LIVES, level=1, pills_left=PILLS_TOTAL.
- Collision: ghost i hits iff ghost_x[i]==pac_x and ghost_y[i]==pac_y; evaluated only in PLAY, combinational compare, registered response.
- PLAY, frightened=1: each hit ghost pulses ghost_eaten[i] once per entry into the same cell (rising edge of per-ghost hit); no life lost.
- PLAY, frightened=0, any hit: life_lost pulse, frightened cleared; lives>1 -> lives-1, RESUME, load delay=RESUME_CYCLES-1; lives==1 -> lives=0, OVER.
- Lethal collision has priority over pill_eaten/power_eaten in the same cycle; the pill is still decremented.
- pill_eaten/power_eaten in PLAY: pills_left-1, saturating at 0. power_eaten also (re)loads fright timer to FRIGHT_CYCLES-1, frightened=1; frightened drops to 0 the cycle after timer reaches 0. Pulses outside PLAY are ignored.
- pills_left reaching 0 with no lethal collision -> CLEAR, delay=CLEAR_CYCLES-1, frightened cleared.
- RESUME: decrement delay; at 0 -> CLEAR if pills_left==0, else PLAY.
- CLEAR: at delay 0 -> level+1 (saturate 15), pills_left=PILLS_TOTAL, RESUME with delay RESUME_CYCLES-1.
- PAUSED: entered from PLAY when pause=1 and no collision this cycle; all timers frozen; pause=0 -> PLAY.
- OVER: terminal until reset; start ignored.
- Single shared delay counter, width $clog2(max(RESUME_CYCLES,CLEAR_CYCLES)); separate fright counter.
- reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
EXTRA_LIFE_EN: defined -> a cumulative pill counter (not cleared on level change, cleared on reset/IDLE start) awards lives+1 (saturate MAX_LIVES) each time it reaches a multiple of EXTRA_LIFE_PILLS; same-cycle lethal collision applies the decrement after the award (net 0). Undefined -> no counter, lives only decrease.

Test Plan:
- Reset, start=1 (N_GHOSTS=2, START_LIVES=3) -> state=1, lives=3, level=1, ghost_enable=1 one cycle after PLAY.
- RESUME_CYCLES=8; ghost1 at pac (5,7), not frightened -> life_lost pulse, lives=2, sprite_reset=1 for 8 cycles, then PLAY.
- power_eaten, FRIGHT_CYCLES=16, ghost0 enters pac cell -> ghost_eaten=2'b01 single pulse, lives unchanged; frightened=0 after 16 cycles.
- PILLS_TOTAL=4, four pill_eaten pulses -> CLEAR, CLEAR_CYCLES elapse, level=2, pills_left=4, RESUME then PLAY.
- lives=1, lethal hit same cycle as last pill -> OVER, lives=0, start ignored; reset -> IDLE.
- EXTRA_LIFE_EN, EXTRA_LIFE_PILLS=3, lives=7 -> 3 pills leaves lives=7 (saturated); from lives=2 -> lives=3.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Pac-Man game-flow FSM: lives, level, pills, power timer, N-ghost collisions; EXTRA_LIFE_EN adds bonus lives.
// Latency: every output is registered, one CLOCK_50 cycle after the inputs/state that cause it.
// Backpressure: none; pill pulses outside PLAY are dropped and PAUSED freezes all timers.
module game_flow_ctrl #(
    parameter int N_GHOSTS         = 2,
    parameter int X_W              = 6,
    parameter int Y_W              = 5,
    parameter int START_LIVES      = 3,
    parameter int MAX_LIVES        = 7,
    parameter int PILLS_TOTAL      = 300,
    parameter int RESUME_CYCLES    = 250000000,
    parameter int CLEAR_CYCLES     = 100000000,
    parameter int FRIGHT_CYCLES    = 300000000,
    parameter int EXTRA_LIFE_PILLS = 1000,
    parameter int LIVES_W          = $clog2(MAX_LIVES + 1),
    parameter int PILL_W           = $clog2(PILLS_TOTAL + 1)
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pause,
    input  logic [X_W-1:0]            pac_x,
    input  logic [Y_W-1:0]            pac_y,
    input  logic [N_GHOSTS*X_W-1:0]   ghost_x,
    input  logic [N_GHOSTS*Y_W-1:0]   ghost_y,
    input  logic                      pill_eaten,
    input  logic                      power_eaten,
    output logic                      sprite_reset,
    output logic                      map_wr_reset,
    output logic                      ghost_enable,
    output logic                      frightened,
    output logic [N_GHOSTS-1:0]       ghost_eaten,
    output logic                      life_lost,
    output logic [LIVES_W-1:0]        lives,
    output logic [3:0]                level,
    output logic [PILL_W-1:0]         pills_left,
    output logic [2:0]                state
);

    localparam int DLY_MAX = (RESUME_CYCLES > CLEAR_CYCLES) ? RESUME_CYCLES : CLEAR_CYCLES;
    localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam int FR_W    = (FRIGHT_CYCLES > 1) ? $clog2(FRIGHT_CYCLES) : 1;

    localparam logic [DLY_W-1:0]   RESUME_LD  = DLY_W'(RESUME_CYCLES - 1);
    localparam logic [DLY_W-1:0]   CLEAR_LD   = DLY_W'(CLEAR_CYCLES - 1);
    localparam logic [FR_W-1:0]    FRIGHT_LD  = FR_W'(FRIGHT_CYCLES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_MAX  = LIVES_W'(MAX_LIVES);
    localparam logic [PILL_W-1:0]  PILLS_INIT = PILL_W'(PILLS_TOTAL);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_RESUME = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_PAUSED = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    state_t               st_q, st_d;
    logic [DLY_W-1:0]     dly_q, dly_d;
    logic [FR_W-1:0]      fr_cnt_q, fr_cnt_d;
    logic                 fright_d;
    logic [LIVES_W-1:0]   lives_d, lives_mid;
    logic [3:0]           level_d;
    logic [PILL_W-1:0]    pills_d;
    logic [N_GHOSTS-1:0]  ghost_eaten_d;
    logic                 life_lost_d;
    logic [N_GHOSTS-1:0]  hit, hit_prev;
    logic                 pill_any;

`ifdef EXTRA_LIFE_EN
    localparam int XL_W = (EXTRA_LIFE_PILLS > 1) ? $clog2(EXTRA_LIFE_PILLS) : 1;
    localparam logic [XL_W-1:0] XL_LAST = XL_W'(EXTRA_LIFE_PILLS - 1);
    // Position within the current bonus-life block of pills; survives level changes.
    logic [XL_W-1:0] xl_q, xl_d;
`endif

    assign state    = st_q;
    assign pill_any = pill_eaten | power_eaten;

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_GHOSTS; i++) begin
            hit[i] = (ghost_x[i*X_W +: X_W] == pac_x) && (ghost_y[i*Y_W +: Y_W] == pac_y);
        end
    end

    always_comb begin
        st_d          = st_q;
        dly_d         = dly_q;
        fr_cnt_d      = fr_cnt_q;
        fright_d      = frightened;
        lives_d       = lives;
        lives_mid     = lives;
        level_d       = level;
        pills_d       = pills_left;
        ghost_eaten_d = '0;
        life_lost_d   = 1'b0;
`ifdef EXTRA_LIFE_EN
        xl_d          = xl_q;
`endif
        case (st_q)
            ST_IDLE: begin
                if (start) begin
                    st_d    = ST_PLAY;
                    lives_d = LIVES_INIT;
                    level_d = 4'd1;
                    pills_d = PILLS_INIT;
`ifdef EXTRA_LIFE_EN
                    xl_d    = '0;
`endif
                end
            end
            ST_PLAY: begin
                if (pill_any && pills_left != '0) pills_d = pills_left - PILL_W'(1);
`ifdef EXTRA_LIFE_EN
                if (pill_any) begin
                    if (xl_q == XL_LAST) begin
                        xl_d = '0;
                        if (lives != LIVES_MAX) lives_mid = lives + LIVES_W'(1);
                    end else begin
                        xl_d = xl_q + XL_W'(1);
                    end
                end
`endif
                lives_d = lives_mid;
                if (power_eaten) begin
                    fr_cnt_d = FRIGHT_LD;
                    fright_d = 1'b1;
                end else if (frightened) begin
                    if (fr_cnt_q == '0) fright_d = 1'b0;
                    else                fr_cnt_d = fr_cnt_q - FR_W'(1);
                end
                if (frightened) ghost_eaten_d = hit & ~hit_prev;
                // A lethal hit outranks level clear and pause; the award above lands first.
                if (!frightened && hit != '0) begin
                    life_lost_d = 1'b1;
                    fright_d    = 1'b0;
                    fr_cnt_d    = '0;
                    if (lives_mid > LIVES_W'(1)) begin
                        lives_d = lives_mid - LIVES_W'(1);
                        st_d    = ST_RESUME;
                        dly_d   = RESUME_LD;
                    end else begin
                        lives_d = '0;
                        st_d    = ST_OVER;
                    end
                end else if (pills_d == '0) begin
                    st_d     = ST_CLEAR;
                    dly_d    = CLEAR_LD;
                    fright_d = 1'b0;
                    fr_cnt_d = '0;
                end else if (pause && hit == '0) begin
                    st_d = ST_PAUSED;
                end
            end
            ST_RESUME: begin
                if (dly_q == '0) begin
                    if (pills_left == '0) begin
                        st_d  = ST_CLEAR;
                        dly_d = CLEAR_LD;
                    end else begin
                        st_d  = ST_PLAY;
                    end
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ST_CLEAR: begin
                if (dly_q == '0) begin
                    level_d = (level == 4'd15) ? level : level + 4'd1;
                    pills_d = PILLS_INIT;
                    st_d    = ST_RESUME;
                    dly_d   = RESUME_LD;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ST_PAUSED: begin
                if (!pause) st_d = ST_PLAY;
            end
            ST_OVER: begin
                st_d = ST_OVER;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            st_q         <= ST_IDLE;
            dly_q        <= '0;
            fr_cnt_q     <= '0;
            frightened   <= 1'b0;
            lives        <= LIVES_INIT;
            level        <= 4'd0;
            pills_left   <= PILLS_INIT;
            ghost_eaten  <= '0;
            life_lost    <= 1'b0;
            hit_prev     <= '0;
            sprite_reset <= 1'b1;
            map_wr_reset <= 1'b1;
            ghost_enable <= 1'b0;
        end else begin
            st_q         <= st_d;
            dly_q        <= dly_d;
            fr_cnt_q     <= fr_cnt_d;
            frightened   <= fright_d;
            lives        <= lives_d;
            level        <= level_d;
            pills_left   <= pills_d;
            ghost_eaten  <= ghost_eaten_d;
            life_lost    <= life_lost_d;
            hit_prev     <= hit;
            // Strobes follow the state one cycle late so consumers see a clean registered edge.
            sprite_reset <= (st_q == ST_IDLE) || (st_q == ST_RESUME) || (st_q == ST_CLEAR);
            map_wr_reset <= (st_q == ST_IDLE) || (st_q == ST_CLEAR) || (st_q == ST_OVER);
            ghost_enable <= (st_q == ST_PLAY);
        end
    end

`ifdef EXTRA_LIFE_EN
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) xl_q <= '0;
        else       xl_q <= xl_d;
    end
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomised bench for game_flow_ctrl: a rule-level reference model feeds an expectation queue
// that a free-running monitor drains and compares one cycle at a time.
module tb_game_flow_ctrl;

    localparam int NG  = 2;
    localparam int XW  = 6;
    localparam int YW  = 5;
    localparam int SL  = 3;
    localparam int ML  = 7;
    localparam int PT  = 4;
    localparam int RC  = 8;
    localparam int CC  = 5;
    localparam int FC  = 16;
    localparam int XLP = 3;
    localparam int LW  = $clog2(ML + 1);
    localparam int PW  = $clog2(PT + 1);

    localparam int P_IDLE = 0, P_PLAY = 1, P_RESUME = 2, P_CLEAR = 3, P_PAUSED = 4, P_OVER = 5;

    logic              CLOCK_50;
    logic              reset, start, pause, pill_eaten, power_eaten;
    logic [XW-1:0]     pac_x;
    logic [YW-1:0]     pac_y;
    logic [NG*XW-1:0]  ghost_x;
    logic [NG*YW-1:0]  ghost_y;
    logic              sprite_reset, map_wr_reset, ghost_enable, frightened, life_lost;
    logic [NG-1:0]     ghost_eaten;
    logic [LW-1:0]     lives;
    logic [3:0]        level;
    logic [PW-1:0]     pills_left;
    logic [2:0]        state;

    game_flow_ctrl #(
        .N_GHOSTS(NG), .X_W(XW), .Y_W(YW), .START_LIVES(SL), .MAX_LIVES(ML),
        .PILLS_TOTAL(PT), .RESUME_CYCLES(RC), .CLEAR_CYCLES(CC),
        .FRIGHT_CYCLES(FC), .EXTRA_LIFE_PILLS(XLP)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .pause(pause),
        .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .pill_eaten(pill_eaten), .power_eaten(power_eaten),
        .sprite_reset(sprite_reset), .map_wr_reset(map_wr_reset),
        .ghost_enable(ghost_enable), .frightened(frightened),
        .ghost_eaten(ghost_eaten), .life_lost(life_lost), .lives(lives),
        .level(level), .pills_left(pills_left), .state(state)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int st, lv, lvl, pills, fr, ll, ge, outs;
    } exp_t;
    exp_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;

    // Reference model: game rules expressed as remaining-cycle counts.
    int m_phase, m_lives, m_level, m_pills, m_fright_left, m_freeze_left, m_cum;
    int m_ll, m_ge, m_outs;
    bit m_prev_hit[NG];

    logic [XW-1:0] gx[NG];
    logic [YW-1:0] gy[NG];

    function automatic int outs_of(input int ph);
        case (ph)
            P_IDLE:   return 3'b110;
            P_PLAY:   return 3'b001;
            P_RESUME: return 3'b100;
            P_CLEAR:  return 3'b110;
            P_OVER:   return 3'b010;
            default:  return 3'b000;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        compared++;
        if (act != exp_v) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.st = m_phase; e.lv = m_lives; e.lvl = m_level; e.pills = m_pills;
        e.fr = (m_fright_left > 0) ? 1 : 0; e.ll = m_ll; e.ge = m_ge; e.outs = m_outs;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_lives = SL; m_level = 0; m_pills = PT;
        m_fright_left = 0; m_freeze_left = 0; m_cum = 0;
        m_ll = 0; m_ge = 0; m_outs = outs_of(P_IDLE);
        for (int i = 0; i < NG; i++) m_prev_hit[i] = 1'b0;
    endtask

    task automatic model_step();
        bit hits[NG];
        bit any_hit, fr, pill;
        int prev_phase;
        prev_phase = m_phase;
        any_hit = 1'b0;
        for (int i = 0; i < NG; i++) begin
            hits[i] = (gx[i] == pac_x) && (gy[i] == pac_y);
            any_hit |= hits[i];
        end
        fr   = (m_fright_left > 0);
        pill = pill_eaten || power_eaten;
        m_ll = 0;
        m_ge = 0;
        case (m_phase)
            P_IDLE: if (start) begin
                m_phase = P_PLAY; m_lives = SL; m_level = 1; m_pills = PT; m_cum = 0;
            end
            P_PLAY: begin
                if (pill && m_pills > 0) m_pills--;
`ifdef EXTRA_LIFE_EN
                if (pill) begin
                    m_cum++;
                    if (m_cum % XLP == 0 && m_lives < ML) m_lives++;
                end
`endif
                if (power_eaten) m_fright_left = FC;
                else if (m_fright_left > 0) m_fright_left--;
                if (fr) for (int i = 0; i < NG; i++) if (hits[i] && !m_prev_hit[i]) m_ge |= (1 << i);
                if (!fr && any_hit) begin
                    m_ll = 1;
                    m_fright_left = 0;
                    if (m_lives > 1) begin
                        m_lives--; m_phase = P_RESUME; m_freeze_left = RC;
                    end else begin
                        m_lives = 0; m_phase = P_OVER;
                    end
                end else if (m_pills == 0) begin
                    m_phase = P_CLEAR; m_freeze_left = CC; m_fright_left = 0;
                end else if (pause && !any_hit) begin
                    m_phase = P_PAUSED;
                end
            end
            P_RESUME: begin
                m_freeze_left--;
                if (m_freeze_left == 0) begin
                    if (m_pills == 0) begin
                        m_phase = P_CLEAR; m_freeze_left = CC;
                    end else begin
                        m_phase = P_PLAY;
                    end
                end
            end
            P_CLEAR: begin
                m_freeze_left--;
                if (m_freeze_left == 0) begin
                    m_level = (m_level < 15) ? m_level + 1 : 15;
                    m_pills = PT; m_phase = P_RESUME; m_freeze_left = RC;
                end
            end
            P_PAUSED: if (!pause) m_phase = P_PLAY;
            default: ;
        endcase
        for (int i = 0; i < NG; i++) m_prev_hit[i] = hits[i];
        m_outs = outs_of(prev_phase);
    endtask

    task automatic pack_ghosts();
        for (int i = 0; i < NG; i++) begin
            ghost_x[i*XW +: XW] = gx[i];
            ghost_y[i*YW +: YW] = gy[i];
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL queue: got empty expectation queue, expected an entry (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("state", int'(state), e.st);
                chk("lives", int'(lives), e.lv);
                chk("level", int'(level), e.lvl);
                chk("pills_left", int'(pills_left), e.pills);
                chk("frightened", int'(frightened), e.fr);
                chk("life_lost", int'(life_lost), e.ll);
                chk("ghost_eaten", int'(ghost_eaten), e.ge);
                chk("strobes", int'({sprite_reset, map_wr_reset, ghost_enable}), e.outs);
            end
        end
    end

    initial begin : driver
        int hit_pm;
        int over_cnt;
        bit do_reset;
        reset = 1'b1; start = 1'b0; pause = 1'b0; pill_eaten = 1'b0; power_eaten = 1'b0;
        pac_x = 6'd5; pac_y = 5'd7;
        for (int i = 0; i < NG; i++) begin
            gx[i] = XW'(40 + i); gy[i] = YW'(20 + i);
        end
        pack_ghosts();
        hit_pm = 3;
        over_cnt = 0;
        model_reset();
        push_exp();
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge CLOCK_50);
            do_reset = (cyc < 2) || (over_cnt >= 20) || ($urandom_range(0, 2999) == 0);
            if (do_reset) begin
                reset = 1'b1;
                over_cnt = 0;
                hit_pm = ($urandom_range(0, 3) == 0) ? 40 : 3;
                model_reset();
                push_exp();
                #1;
                chk("async_reset_state", int'(state), P_IDLE);
                chk("async_reset_lives", int'(lives), SL);
                chk("async_reset_pills", int'(pills_left), PT);
            end else begin
                reset = 1'b0;
                start = 1'($urandom_range(0, 1));
                if (pause) pause = ($urandom_range(0, 99) < 15) ? 1'b0 : 1'b1;
                else       pause = ($urandom_range(0, 999) < 15) ? 1'b1 : 1'b0;
                if ($urandom_range(0, 99) < 3) begin
                    pac_x = XW'($urandom_range(0, 63));
                    pac_y = YW'($urandom_range(0, 31));
                end
                for (int i = 0; i < NG; i++) begin
                    int r;
                    r = $urandom_range(0, 999);
                    if (r < hit_pm) begin
                        gx[i] = pac_x; gy[i] = pac_y;
                    end else if (r < hit_pm + 60) begin
                        gx[i] = XW'($urandom_range(0, 63));
                        gy[i] = YW'($urandom_range(0, 31));
                    end
                end
                begin
                    int r;
                    r = $urandom_range(0, 99);
                    pill_eaten  = (r < 12);
                    power_eaten = (r >= 12 && r < 15);
                end
                // Steer toward a lethal hit landing on the last pill of a level.
                if (m_phase == P_PLAY && m_pills == 1 && m_fright_left == 0 &&
                    $urandom_range(0, 3) == 0) begin
                    pill_eaten = 1'b1; power_eaten = 1'b0;
                    gx[0] = pac_x; gy[0] = pac_y;
                end
                pack_ghosts();
                model_step();
                push_exp();
                if (m_phase == P_OVER) over_cnt++;
            end
        end
        @(posedge CLOCK_50);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
